// File: rtl/cpu_mem_pkg.sv
// Shared memory-side definitions for the Dcache write path: write types,
// line geometry and the one-hot write-buffer FSM encodings.
package cpu_mem_pkg;

  localparam int LINE_OFF_BITS = 4;

  typedef enum logic [1:0] {
    WR_TYPE_WORD = 2'b00,
    WR_TYPE_LINE = 2'b01
  } wr_type_e;

  localparam logic [2:0] WB_IDLE = 3'b001;
  localparam logic [2:0] WB_SEND = 3'b010;
  localparam logic [2:0] WB_WAIT = 3'b100;

  function automatic wr_type_e wr_type_from_req(input logic is_line);
    return is_line ? WR_TYPE_LINE : WR_TYPE_WORD;
  endfunction

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between Dcache, the write buffer and the AXI write bridge.
// slave = the write buffer itself, master = the surrounding environment.
interface dcache_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              cache_wr_req;
  logic              cache_wr_type;
  logic [ADDR_W-1:0] cache_wr_addr;
  logic [3:0]        cache_wr_wstrb;
  logic [LINE_W-1:0] cache_wr_data;
  logic              cache_wr_rdy;

  logic              axi_wr_req;
  logic [1:0]        axi_wr_type;
  logic [ADDR_W-1:0] axi_wr_addr;
  logic [3:0]        axi_wr_wstrb;
  logic [LINE_W-1:0] axi_wr_data;
  logic              axi_wr_rdy;
  logic              axi_wr_done;

  logic [ADDR_W-1:0] rd_chk_addr;
  logic              rd_conflict;
  logic              wb_empty;

  modport slave (
    input  cache_wr_req, cache_wr_type, cache_wr_addr, cache_wr_wstrb, cache_wr_data,
    output cache_wr_rdy,
    output axi_wr_req, axi_wr_type, axi_wr_addr, axi_wr_wstrb, axi_wr_data,
    input  axi_wr_rdy, axi_wr_done,
    input  rd_chk_addr,
    output rd_conflict, wb_empty
  );

  modport master (
    output cache_wr_req, cache_wr_type, cache_wr_addr, cache_wr_wstrb, cache_wr_data,
    input  cache_wr_rdy,
    input  axi_wr_req, axi_wr_type, axi_wr_addr, axi_wr_wstrb, axi_wr_data,
    output axi_wr_rdy, axi_wr_done,
    output rd_chk_addr,
    input  rd_conflict, wb_empty
  );
endinterface

// File: rtl/wb_entry_fifo.sv
// In-order entry storage for the write buffer, with a per-entry line-address
// compare so the read path can see any queued write to the same line.
module wb_entry_fifo
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wr_type_e          push_kind_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [3:0]        push_wstrb_i,
  input  logic [LINE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output wr_type_e          head_kind_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [3:0]        head_wstrb_o,
  output logic [LINE_W-1:0] head_data_o,
  input  logic [ADDR_W-1:0] chk_addr_i,
  output logic [DEPTH-1:0]  match_o
);

  localparam logic [ADDR_W-1:0] TAG_MASK = ~ADDR_W'((1 << LINE_OFF_BITS) - 1);

  wr_type_e          kind_q  [DEPTH];
  wr_type_e          kind_d  [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [3:0]        wstrb_q [DEPTH];
  logic [3:0]        wstrb_d [DEPTH];
  logic [LINE_W-1:0] data_q  [DEPTH];
  logic [LINE_W-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    kind_d  = kind_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      kind_d[tail_q]  = push_kind_i;
      addr_d[tail_q]  = push_addr_i;
      wstrb_d[tail_q] = push_wstrb_i;
      data_d[tail_q]  = push_data_i;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: valid_q alone decides what is live.
  always_ff @(posedge clk) begin
    kind_q  <= kind_d;
    addr_q  <= addr_d;
    wstrb_q <= wstrb_d;
    data_q  <= data_d;
  end

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign head_kind_o  = kind_q[head_q];
  assign head_addr_o  = addr_q[head_q];
  assign head_wstrb_o = wstrb_q[head_q];
  assign head_data_o  = data_q[head_q];

  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_q[i] && ((addr_q[i] & TAG_MASK) == (chk_addr_i & TAG_MASK));
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Dcache write buffer: queues line writebacks and uncached word stores and
// drains them to the AXI write bridge one at a time, strictly in order.
//
//   state   | meaning
//   WB_IDLE | no request out; moves to SEND when an entry is queued
//   WB_SEND | axi_wr_req high with head fields; waits for axi_wr_rdy
//   WB_WAIT | request accepted; waits for axi_wr_done, then pops head
module dcache_write_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  dcache_write_buffer_if.slave  wb
);

  localparam logic [ADDR_W-1:0] TAG_MASK = ~ADDR_W'((1 << LINE_OFF_BITS) - 1);

  logic [2:0]        state_q, state_d;
  logic              push, pop, full, empty;
  wr_type_e          head_kind;
  logic [ADDR_W-1:0] head_addr;
  logic [3:0]        head_wstrb;
  logic [LINE_W-1:0] head_data;
  logic [DEPTH-1:0]  match_vec;
  logic              head_is_line;

  // A full buffer refuses even when a pop lands in the same cycle.
  assign wb.cache_wr_rdy = !reset && !full;
  assign push            = wb.cache_wr_req && wb.cache_wr_rdy;
  assign pop             = (state_q == WB_WAIT) && wb.axi_wr_done;

  wb_entry_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_kind_i  (wr_type_from_req(wb.cache_wr_type)),
    .push_addr_i  (wb.cache_wr_addr),
    .push_wstrb_i (wb.cache_wr_wstrb),
    .push_data_i  (wb.cache_wr_data),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_kind_o  (head_kind),
    .head_addr_o  (head_addr),
    .head_wstrb_o (head_wstrb),
    .head_data_o  (head_data),
    .chk_addr_i   (wb.rd_chk_addr),
    .match_o      (match_vec)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE: if (!empty)          state_d = WB_SEND;
      WB_SEND: if (wb.axi_wr_rdy)   state_d = WB_WAIT;
      WB_WAIT: if (wb.axi_wr_done)  state_d = WB_IDLE;
      default:                      state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= WB_IDLE;
    else       state_q <= state_d;
  end

  assign head_is_line    = (head_kind == WR_TYPE_LINE);
  assign wb.axi_wr_req   = (state_q == WB_SEND);
  assign wb.axi_wr_type  = head_kind;
  assign wb.axi_wr_addr  = head_is_line ? (head_addr & TAG_MASK) : head_addr;
  assign wb.axi_wr_wstrb = head_is_line ? 4'hf : head_wstrb;
  assign wb.axi_wr_data  = head_data;

  assign wb.rd_conflict  = |match_vec;
  assign wb.wb_empty     = empty && (state_q == WB_IDLE);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: table-driven single-entry vectors
// plus hand-written sequences for full, ordering, wrap and reset corners.
module tb_dcache_write_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_write_buffer_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(32), .LINE_W(128)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_wr(input logic req, input logic is_line, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [127:0] data);
    bus.cache_wr_req   = req;
    bus.cache_wr_type  = is_line;
    bus.cache_wr_addr  = addr;
    bus.cache_wr_wstrb = wstrb;
    bus.cache_wr_data  = data;
  endtask

  // Waits for the head request, checks it, then completes the rdy/done handshake.
  task automatic drain_one(input string tag, input logic [31:0] exp_addr,
                           input logic [1:0] exp_type, input logic [127:0] exp_data);
    int n = 0;
    #1;
    while (!bus.axi_wr_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.axi_wr_req) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no axi_wr_req expected request within 20 cycles", tag);
      return;
    end
    chk({tag, "_addr"}, bus.axi_wr_addr, exp_addr);
    chk({tag, "_type"}, bus.axi_wr_type, exp_type);
    chk({tag, "_data"}, bus.axi_wr_data, exp_data);
    bus.axi_wr_rdy = 1'b1;
    @(negedge clk);
    bus.axi_wr_rdy  = 1'b0;
    bus.axi_wr_done = 1'b1;
    @(negedge clk);
    bus.axi_wr_done = 1'b0;
  endtask

  typedef struct {
    logic         is_line;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
    logic [1:0]   exp_type;
    logic [31:0]  exp_addr;
    logic [3:0]   exp_wstrb;
    logic [31:0]  hit_addr;
    logic [31:0]  miss_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 32'h1000_0010, 4'h0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA,
                2'b01, 32'h1000_0010, 4'hf, 32'h1000_001C, 32'h1000_0020};
    vecs[1] = '{1'b0, 32'hBFAF_F004, 4'b0011, 128'h1234,
                2'b00, 32'hBFAF_F004, 4'b0011, 32'hBFAF_F00C, 32'hBFAF_F014};
    vecs[2] = '{1'b1, 32'h2000_0040, 4'h5, 128'h0F0F_0F0F,
                2'b01, 32'h2000_0040, 4'hf, 32'h2000_004C, 32'h2000_0050};
    vecs[3] = '{1'b1, 32'h4000_00AC, 4'h0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BABE,
                2'b01, 32'h4000_00A0, 4'hf, 32'h4000_00A0, 32'h4000_00B0};
    vecs[4] = '{1'b0, 32'h0000_0003, 4'b1000, 128'h55,
                2'b00, 32'h0000_0003, 4'b1000, 32'h0000_000F, 32'h1000_0000};

    reset           = 1'b1;
    bus.axi_wr_rdy  = 1'b0;
    bus.axi_wr_done = 1'b0;
    bus.rd_chk_addr = 32'h0;
    set_wr(1'b0, 1'b0, 32'h0, 4'h0, 128'h0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy_low", bus.cache_wr_rdy, 1'b0);
    chk("rst_req", bus.axi_wr_req, 1'b0);
    chk("rst_empty", bus.wb_empty, 1'b1);
    chk("rst_conflict", bus.rd_conflict, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", bus.cache_wr_rdy, 1'b1);

    // Single-entry vectors: latency, field muxing, stall stability, hazard window.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_wr(1'b1, vecs[i].is_line, vecs[i].addr, vecs[i].wstrb, vecs[i].data);
      bus.rd_chk_addr = vecs[i].hit_addr;
      #1;
      chk("v_rdy", bus.cache_wr_rdy, 1'b1);
      chk("v_hz_pre", bus.rd_conflict, 1'b0);
      chk("v_empty_pre", bus.wb_empty, 1'b1);
      @(negedge clk);
      bus.cache_wr_req = 1'b0;
      #1;
      chk("v_lat1_req", bus.axi_wr_req, 1'b0);
      chk("v_hz_n1", bus.rd_conflict, 1'b1);
      chk("v_empty_n1", bus.wb_empty, 1'b0);
      @(negedge clk); #1;
      chk("v_lat2_req", bus.axi_wr_req, 1'b1);
      chk("v_type", bus.axi_wr_type, vecs[i].exp_type);
      chk("v_addr", bus.axi_wr_addr, vecs[i].exp_addr);
      chk("v_wstrb", bus.axi_wr_wstrb, vecs[i].exp_wstrb);
      chk("v_data", bus.axi_wr_data, vecs[i].data);
      for (int s = 0; s < 3; s++) begin
        @(negedge clk); #1;
        chk("v_stall_req", bus.axi_wr_req, 1'b1);
        chk("v_stall_addr", bus.axi_wr_addr, vecs[i].exp_addr);
      end
      bus.axi_wr_rdy = 1'b1;
      @(negedge clk);
      bus.axi_wr_rdy = 1'b0;
      #1;
      chk("v_wait_req", bus.axi_wr_req, 1'b0);
      chk("v_hz_wait", bus.rd_conflict, 1'b1);
      bus.rd_chk_addr = vecs[i].miss_addr;
      #1;
      chk("v_hz_miss", bus.rd_conflict, 1'b0);
      bus.rd_chk_addr = vecs[i].hit_addr;
      bus.axi_wr_done = 1'b1;
      #1;
      chk("v_hz_pop", bus.rd_conflict, 1'b1);
      chk("v_empty_pop", bus.wb_empty, 1'b0);
      @(negedge clk);
      bus.axi_wr_done = 1'b0;
      #1;
      chk("v_empty_done", bus.wb_empty, 1'b1);
      chk("v_hz_done", bus.rd_conflict, 1'b0);
    end

    // Fill with bridge stalled, then pop while a 5th request waits.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_wr(1'b1, 1'b1, 32'h5000_0000 + 32'(k * 16), 4'h0, 128'(k));
      #1;
      chk("full_push_rdy", bus.cache_wr_rdy, 1'b1);
    end
    @(negedge clk);
    set_wr(1'b1, 1'b1, 32'h5000_0040, 4'h0, 128'd4);
    #1;
    chk("full_rdy", bus.cache_wr_rdy, 1'b0);
    @(negedge clk); #1;
    chk("full_hold_rdy", bus.cache_wr_rdy, 1'b0);
    chk("full_head_req", bus.axi_wr_req, 1'b1);
    chk("full_head_addr", bus.axi_wr_addr, 32'h5000_0000);
    bus.axi_wr_rdy = 1'b1;
    @(negedge clk);
    bus.axi_wr_rdy  = 1'b0;
    bus.axi_wr_done = 1'b1;
    #1;
    chk("full_pop_refuse", bus.cache_wr_rdy, 1'b0);
    @(negedge clk);
    bus.axi_wr_done = 1'b0;
    #1;
    chk("full_after_pop_rdy", bus.cache_wr_rdy, 1'b1);
    @(negedge clk);
    bus.cache_wr_req = 1'b0;
    #1;
    chk("full_refull", bus.cache_wr_rdy, 1'b0);
    for (int k = 1; k < 5; k++) begin
      drain_one("full_drain", 32'h5000_0000 + 32'(k * 16), 2'b01, 128'(k));
    end

    // Mixed line/word ordering.
    @(negedge clk);
    set_wr(1'b1, 1'b1, 32'h3000_0108, 4'h0, 128'hA);
    @(negedge clk);
    set_wr(1'b1, 1'b0, 32'h3000_0204, 4'b0110, 128'hB);
    @(negedge clk);
    set_wr(1'b1, 1'b1, 32'h3000_0300, 4'h0, 128'hC);
    @(negedge clk);
    bus.cache_wr_req = 1'b0;
    drain_one("ord_a", 32'h3000_0100, 2'b01, 128'hA);
    chk("ord_b_wstrb_pre", bus.axi_wr_wstrb, 4'b0110);
    drain_one("ord_b", 32'h3000_0204, 2'b00, 128'hB);
    drain_one("ord_c", 32'h3000_0300, 2'b01, 128'hC);

    // Fill/drain rounds to wrap head/tail repeatedly.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        set_wr(1'b1, k[0], 32'h6000_0000 + 32'(r * 256) + 32'(k * 16), 4'h1, 128'(r * 16 + k));
        #1;
        chk("wrap_rdy", bus.cache_wr_rdy, 1'b1);
      end
      @(negedge clk);
      bus.cache_wr_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        drain_one("wrap", 32'h6000_0000 + 32'(r * 256) + 32'(k * 16),
                  k[0] ? 2'b01 : 2'b00, 128'(r * 16 + k));
      end
      #1;
      chk("wrap_empty", bus.wb_empty, 1'b1);
    end

    // Reset while a write is in WAIT.
    @(negedge clk);
    set_wr(1'b1, 1'b1, 32'h7000_0010, 4'h0, 128'h77);
    bus.rd_chk_addr = 32'h7000_0010;
    @(negedge clk);
    bus.cache_wr_req = 1'b0;
    @(negedge clk); #1;
    chk("rw_req", bus.axi_wr_req, 1'b1);
    bus.axi_wr_rdy = 1'b1;
    @(negedge clk);
    bus.axi_wr_rdy = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_rst_rdy_low", bus.cache_wr_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_req_after", bus.axi_wr_req, 1'b0);
    chk("rw_empty_after", bus.wb_empty, 1'b1);
    chk("rw_conflict_after", bus.rd_conflict, 1'b0);
    bus.axi_wr_done = 1'b1;
    bus.axi_wr_rdy  = 1'b1;
    @(negedge clk);
    bus.axi_wr_done = 1'b0;
    bus.axi_wr_rdy  = 1'b0;
    #1;
    chk("rw_stray_empty", bus.wb_empty, 1'b1);
    chk("rw_stray_req", bus.axi_wr_req, 1'b0);
    @(negedge clk);
    set_wr(1'b1, 1'b0, 32'h7000_0024, 4'b0001, 128'h99);
    @(negedge clk);
    bus.cache_wr_req = 1'b0;
    drain_one("rw_post", 32'h7000_0024, 2'b00, 128'h99);
    #1;
    chk("rw_post_empty", bus.wb_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
